// File: rtl/usd_apu_sequencer.sv
`default_nettype none
// ============================================================================
// usd_apu_sequencer
//   Expands multi-block host read/write requests into single-block SD
//   commands (CMD17/CMD24) and moves block data and results.
//   Revision: 1.0
// ============================================================================
module usd_apu_sequencer #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF,
  parameter int unsigned WORDS_PER_BLK  = 64
) (
  input  logic        apuClk,
  input  logic        sysRst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqBlockAddr,
  input  logic [15:0] reqBlockCount,
  input  logic [63:0] wrData,
  input  logic        wrValid,
  output logic        wrReady,
  output logic [63:0] rdData,
  output logic        rdValid,
  output logic        doneStrobe,
  output logic [3:0]  doneStatus,
  output logic [31:0] doneCardStatus,
  output logic [71:0] cmdFifoData,
  output logic        cmdFifoWrEn,
  input  logic        cmdRdyRd,
  output logic [71:0] cmdDataFifoData,
  output logic        cmdDataFifoWrEn,
  input  logic        cmdRdyWr,
  input  logic        resultPending,
  output logic        resultFifoRdEn,
  input  logic [35:0] resultFifoData,
  input  logic        rdFifoAvail,
  output logic        resultDataFifoRdEn,
  input  logic [71:0] resultDataFifoData
);

  localparam int unsigned CNT_W = $clog2(WORDS_PER_BLK + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);
  localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(WORDS_PER_BLK);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WR_DATA  = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_POP_RES  = 3'd4;
  localparam logic [2:0] S_CHECK    = 3'd5;
  localparam logic [2:0] S_RD_DATA  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [3:0] ST_OK      = 4'd0;
  localparam logic [3:0] ST_CARD    = 4'd1;
  localparam logic [3:0] ST_TIMEOUT = 4'd2;

  logic [2:0]       state;
  logic             is_write;
  logic [31:0]      base_addr;
  logic [15:0]      blk_count;
  logic [15:0]      blk_idx;
  logic [CNT_W-1:0] word_cnt;
  logic [23:0]      timer;
  logic [3:0]       status;
  logic [31:0]      card_status;
  logic             rd_valid_q;

  logic [15:0]      blk_next;
  logic             last_blk;
  logic             wr_accept;
  logic             rd_pop;
  logic             timer_hit;
  logic [31:0]      cmd_arg;
  logic             unused_bits;

  assign blk_next  = blk_idx + 16'd1;
  assign last_blk  = (blk_next == blk_count);
  assign cmd_arg   = base_addr + {16'd0, blk_idx};
  assign wr_accept = (state == S_WR_DATA) && cmdRdyWr && wrValid;
  assign rd_pop    = (state == S_RD_DATA) && rdFifoAvail && (word_cnt != ALL_WORDS);
  // Hit on the cycle that would make the elapsed WAIT_RES count reach the limit.
  assign timer_hit = ({1'b0, timer} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};

  assign reqReady           = (state == S_IDLE);
  assign cmdFifoWrEn        = (state == S_ISSUE) && cmdRdyRd;
  assign cmdFifoData        = (state == S_ISSUE) ?
                              {8'h00, (is_write ? 6'd24 : 6'd17), 26'd0, cmd_arg} : 72'd0;
  assign wrReady            = (state == S_WR_DATA) && cmdRdyWr;
  assign cmdDataFifoWrEn    = wr_accept;
  assign cmdDataFifoData    = (state == S_WR_DATA) ? {8'h00, wrData} : 72'd0;
  assign resultFifoRdEn     = (state == S_POP_RES);
  assign resultDataFifoRdEn = rd_pop;
  assign rdValid            = rd_valid_q;
  // The read FIFO presents its word the cycle after the pop, so it is passed straight through.
  assign rdData             = rd_valid_q ? resultDataFifoData[63:0] : 64'd0;
  assign doneStrobe         = (state == S_DONE);
  assign doneStatus         = status;
  assign doneCardStatus     = card_status;

  assign unused_bits = &{1'b0, resultDataFifoData[71:64]};

  always_ff @(posedge apuClk) begin
    if (sysRst) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      base_addr   <= 32'd0;
      blk_count   <= 16'd0;
      blk_idx     <= 16'd0;
      word_cnt    <= '0;
      timer       <= 24'd0;
      status      <= ST_OK;
      card_status <= 32'd0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_pop;

      if (state != S_WAIT_RES) begin
        timer <= 24'd0;
      end else if (timer != 24'hFFFFFF) begin
        timer <= timer + 24'd1;
      end

      case (state)
        S_IDLE: begin
          if (reqValid) begin
            is_write    <= reqWrite;
            base_addr   <= reqBlockAddr;
            blk_count   <= reqBlockCount;
            blk_idx     <= 16'd0;
            word_cnt    <= '0;
            status      <= ST_OK;
            card_status <= 32'd0;
            state       <= (reqBlockCount == 16'd0) ? S_DONE : S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (cmdRdyRd) begin
            word_cnt <= '0;
            state    <= is_write ? S_WR_DATA : S_WAIT_RES;
          end
        end

        S_WR_DATA: begin
          if (wr_accept) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              state    <= S_WAIT_RES;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end

        S_WAIT_RES: begin
          if (resultPending) begin
            state <= S_POP_RES;
          end else if (timer_hit) begin
            status <= ST_TIMEOUT;
            state  <= S_DONE;
          end
        end

        S_POP_RES: state <= S_CHECK;

        S_CHECK: begin
          card_status <= resultFifoData[31:0];
          if (resultFifoData[35:32] != 4'd0) begin
            status <= ST_CARD;
            state  <= S_DONE;
          end else if (!is_write) begin
            word_cnt <= '0;
            state    <= S_RD_DATA;
          end else begin
            blk_idx <= blk_next;
            state   <= last_blk ? S_DONE : S_ISSUE;
          end
        end

        S_RD_DATA: begin
          if (rd_pop) begin
            word_cnt <= word_cnt + CNT_W'(1);
          end
          // All pops done; the last word is on rdData this cycle.
          if (word_cnt == ALL_WORDS) begin
            blk_idx <= blk_next;
            state   <= last_blk ? S_DONE : S_ISSUE;
          end
        end

        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usd_apu_sequencer.sv
`default_nettype none
// Bench for usd_apu_sequencer: FIFO models on the controller side, scoreboard
// queues for commands, write words and read words, directed request sequence.
module tb_usd_apu_sequencer;

  logic        apuClk = 1'b0;
  logic        sysRst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [31:0] reqBlockAddr = 32'd0;
  logic [15:0] reqBlockCount = 16'd0;
  logic [63:0] wrData = 64'd0;
  logic        wrValid = 1'b0;
  logic        wrReady;
  logic [63:0] rdData;
  logic        rdValid;
  logic        doneStrobe;
  logic [3:0]  doneStatus;
  logic [31:0] doneCardStatus;
  logic [71:0] cmdFifoData;
  logic        cmdFifoWrEn;
  logic        cmdRdyRd = 1'b0;
  logic [71:0] cmdDataFifoData;
  logic        cmdDataFifoWrEn;
  logic        cmdRdyWr = 1'b1;
  logic        resultPending = 1'b0;
  logic        resultFifoRdEn;
  logic [35:0] resultFifoData = 36'd0;
  logic        rdFifoAvail = 1'b0;
  logic        resultDataFifoRdEn;
  logic [71:0] resultDataFifoData = 72'd0;

  always #5 apuClk = ~apuClk;

  usd_apu_sequencer #(.TIMEOUT_CYCLES(24'd100), .WORDS_PER_BLK(64)) dut (
    .apuClk(apuClk), .sysRst(sysRst),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqBlockAddr(reqBlockAddr), .reqBlockCount(reqBlockCount),
    .wrData(wrData), .wrValid(wrValid), .wrReady(wrReady),
    .rdData(rdData), .rdValid(rdValid),
    .doneStrobe(doneStrobe), .doneStatus(doneStatus), .doneCardStatus(doneCardStatus),
    .cmdFifoData(cmdFifoData), .cmdFifoWrEn(cmdFifoWrEn), .cmdRdyRd(cmdRdyRd),
    .cmdDataFifoData(cmdDataFifoData), .cmdDataFifoWrEn(cmdDataFifoWrEn), .cmdRdyWr(cmdRdyWr),
    .resultPending(resultPending), .resultFifoRdEn(resultFifoRdEn), .resultFifoData(resultFifoData),
    .rdFifoAvail(rdFifoAvail), .resultDataFifoRdEn(resultDataFifoRdEn),
    .resultDataFifoData(resultDataFifoData)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [71:0] exp_cmd[$];
  logic [63:0] exp_wr[$];
  logic [63:0] exp_rd[$];
  logic [35:0] res_script[$];
  logic [35:0] resq[$];
  logic [63:0] rdq[$];
  logic [63:0] wq[$];

  int cmd_pushes = 0, data_pushes = 0, rd_strobes = 0, res_pops = 0, done_cnt = 0;
  int last_cmd_cyc = 0, done_cyc = 0, data_since_cmd = 0;
  logic [3:0]  done_status = 4'd0;
  logic [31:0] done_card = 32'd0;
  bit last_is_write = 1'b0, wr_pending = 1'b0, hold_results = 1'b0;
  bit stall_rd = 1'b0, stall_cmd = 1'b0, res_load = 1'b0, rd_load = 1'b0;
  logic [35:0] pending_res = 36'd0, res_next = 36'd0;
  logic [63:0] rd_next = 64'd0;
  logic prev_cmd_en = 1'b0, prev_res_en = 1'b0, prev_done = 1'b0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {8'h00, idx, 26'd0, arg};
  endfunction

  // Controller-side observation: scoreboard pops and FIFO model reactions.
  always @(negedge apuClk) begin
    logic [71:0] e;
    logic [35:0] r;
    logic [63:0] w;
    if (prev_cmd_en) check("cmd_pulse", 72'(cmdFifoWrEn), 72'd0);
    if (prev_res_en) check("res_pulse", 72'(resultFifoRdEn), 72'd0);
    if (prev_done)   check("done_pulse", 72'(doneStrobe), 72'd0);

    if (rdValid) begin
      rd_strobes++;
      if (exp_rd.size() == 0) check("rd_unexpected", 72'(rdValid), 72'd0);
      else check("rd_word", 72'(rdData), 72'(exp_rd.pop_front()));
    end

    if (cmdFifoWrEn) begin
      cmd_pushes++;
      last_cmd_cyc = cyc;
      data_since_cmd = 0;
      if (exp_cmd.size() == 0) begin
        check("cmd_unexpected", 72'(cmdFifoWrEn), 72'd0);
        last_is_write = 1'b0;
      end else begin
        e = exp_cmd.pop_front();
        check("cmd_word", cmdFifoData, e);
        last_is_write = (e[63:58] == 6'd24);
      end
      r = (res_script.size() > 0) ? res_script.pop_front() : 36'd0;
      if (last_is_write) begin
        pending_res = r;
        wr_pending = 1'b1;
      end else begin
        resq.push_back(r);
        for (int k = 0; k < 64; k++) begin
          w = {$urandom, $urandom};
          rdq.push_back(w);
          if (r[35:32] == 4'd0) exp_rd.push_back(w);
        end
      end
    end

    if (cmdDataFifoWrEn) begin
      data_pushes++;
      data_since_cmd++;
      if (exp_wr.size() == 0) check("wr_unexpected", 72'(cmdDataFifoWrEn), 72'd0);
      else check("wr_word", cmdDataFifoData, {8'h00, exp_wr.pop_front()});
      if (wr_pending && data_since_cmd == 64) begin
        resq.push_back(pending_res);
        wr_pending = 1'b0;
      end
    end

    if (resultFifoRdEn) begin
      res_pops++;
      if (resq.size() == 0) check("res_underflow", 72'(resultFifoRdEn), 72'd0);
      else begin
        res_next = resq.pop_front();
        res_load = 1'b1;
      end
      if (last_is_write) check("wr_before_res", 72'(data_since_cmd), 72'd64);
    end

    if (resultDataFifoRdEn) begin
      if (rdq.size() == 0) check("rdq_underflow", 72'(resultDataFifoRdEn), 72'd0);
      else begin
        rd_next = rdq.pop_front();
        rd_load = 1'b1;
      end
    end

    if (doneStrobe) begin
      done_cnt++;
      done_status = doneStatus;
      done_card = doneCardStatus;
      done_cyc = cyc;
    end

    prev_cmd_en = cmdFifoWrEn;
    prev_res_en = resultFifoRdEn;
    prev_done = doneStrobe;
  end

  // FIFO models present popped data the cycle after the pop.
  always @(posedge apuClk) begin
    cyc++;
    #1;
    if (res_load) begin resultFifoData = res_next; res_load = 1'b0; end
    if (rd_load) begin resultDataFifoData = {8'h5A, rd_next}; rd_load = 1'b0; end
    resultPending = (resq.size() > 0) && !hold_results;
    rdFifoAvail = (rdq.size() > 0) && (!stall_rd || ($urandom_range(3, 0) != 0));
    cmdRdyRd = !stall_cmd || ($urandom_range(3, 0) != 0);
  end

  task automatic tick_drive();
    @(posedge apuClk); #1;
  endtask

  task automatic tick_sample();
    @(negedge apuClk); #1;
  endtask

  task automatic clear_env();
    exp_cmd.delete(); exp_wr.delete(); exp_rd.delete(); res_script.delete();
    resq.delete(); rdq.delete(); wq.delete();
    wr_pending = 1'b0; res_load = 1'b0; rd_load = 1'b0;
  endtask

  task automatic issue_req(input bit wr, input logic [31:0] addr, input logic [15:0] cnt,
                           output int acc);
    tick_drive();
    reqValid = 1'b1; reqWrite = wr; reqBlockAddr = addr; reqBlockCount = cnt;
    tick_sample();
    check("req_ready", 72'(reqReady), 72'd1);
    acc = cyc;
    tick_drive();
    reqValid = 1'b0;
  endtask

  task automatic wait_done(input int base, input int limit);
    int n = 0;
    while (done_cnt == base && n < limit) begin
      tick_sample();
      n++;
    end
    if (done_cnt == base) check("done_wait_expired", 72'(done_cnt), 72'(base + 1));
  endtask

  task automatic drive_words(input bit toggle);
    int k = 0;
    int guard = 0;
    int total = wq.size();
    while (k < total && guard < 3000) begin
      tick_drive();
      wrValid = 1'b1;
      wrData = wq[k];
      if (toggle) cmdRdyWr = ~cmdRdyWr;
      @(negedge apuClk);
      if (wrReady) k++;
      guard++;
    end
    if (k < total) check("wr_drive_expired", 72'(k), 72'(total));
    tick_drive();
    wrValid = 1'b0;
    cmdRdyWr = 1'b1;
  endtask

  initial begin
    int acc;
    int b_cmd, b_data, b_rd, b_done, b_res, n;
    logic [63:0] w;

    repeat (3) @(posedge apuClk);
    tick_sample();
    check("rst_reqReady", 72'(reqReady), 72'd1);
    check("rst_cmdWrEn", 72'(cmdFifoWrEn), 72'd0);
    check("rst_cmdData", cmdFifoData, 72'd0);
    check("rst_dataWrEn", 72'(cmdDataFifoWrEn), 72'd0);
    check("rst_wrReady", 72'(wrReady), 72'd0);
    check("rst_resRdEn", 72'(resultFifoRdEn), 72'd0);
    check("rst_rdDataRdEn", 72'(resultDataFifoRdEn), 72'd0);
    check("rst_rdValid", 72'(rdValid), 72'd0);
    check("rst_rdData", 72'(rdData), 72'd0);
    check("rst_done", 72'(doneStrobe), 72'd0);
    check("rst_doneStatus", 72'(doneStatus), 72'd0);
    check("rst_doneCard", 72'(doneCardStatus), 72'd0);
    tick_drive();
    sysRst = 1'b0;

    // Read, two blocks, with random command and read-FIFO stalls.
    stall_rd = 1'b1; stall_cmd = 1'b1;
    res_script.push_back({4'h0, 32'h0000_0AAA});
    res_script.push_back({4'h0, 32'h0000_0BBB});
    exp_cmd.push_back(mk_cmd(6'd17, 32'h0000_0100));
    exp_cmd.push_back(mk_cmd(6'd17, 32'h0000_0101));
    b_rd = rd_strobes; b_done = done_cnt;
    issue_req(1'b0, 32'h0000_0100, 16'd2, acc);
    wait_done(b_done, 2000);
    check("t1_status", 72'(done_status), 72'd0);
    check("t1_card", 72'(done_card), 72'h0BBB);
    check("t1_rd_count", 72'(rd_strobes - b_rd), 72'd128);
    check("t1_rd_left", 72'(exp_rd.size()), 72'd0);
    check("t1_cmd_left", 72'(exp_cmd.size()), 72'd0);
    clear_env();

    // Write, two blocks, address wraps; cmdRdyWr toggles every cycle.
    stall_rd = 1'b0; stall_cmd = 1'b0;
    tick_drive();
    for (int i = 0; i < 128; i++) begin
      w = {$urandom, $urandom};
      exp_wr.push_back(w);
      wq.push_back(w);
    end
    res_script.push_back({4'h0, 32'h0000_0011});
    res_script.push_back({4'h0, 32'h0000_0055});
    exp_cmd.push_back(mk_cmd(6'd24, 32'hFFFF_FFFF));
    exp_cmd.push_back(mk_cmd(6'd24, 32'h0000_0000));
    b_cmd = cmd_pushes; b_data = data_pushes; b_done = done_cnt;
    issue_req(1'b1, 32'hFFFF_FFFF, 16'd2, acc);
    tick_sample();
    check("t2_first_cmd", 72'(cmd_pushes - b_cmd), 72'd1);
    check("t2_cmd_latency", 72'(last_cmd_cyc), 72'(acc + 1));
    drive_words(1'b1);
    wait_done(b_done, 1000);
    check("t2_status", 72'(done_status), 72'd0);
    check("t2_card", 72'(done_card), 72'h55);
    check("t2_data_count", 72'(data_pushes - b_data), 72'd128);
    check("t2_wr_left", 72'(exp_wr.size()), 72'd0);
    check("t2_cmd_count", 72'(cmd_pushes - b_cmd), 72'd2);
    clear_env();

    // Read, three blocks; second result reports a card error.
    stall_rd = 1'b1;
    res_script.push_back({4'h0, 32'h0000_0001});
    res_script.push_back({4'h1, 32'h0000_0900});
    exp_cmd.push_back(mk_cmd(6'd17, 32'h0000_0020));
    exp_cmd.push_back(mk_cmd(6'd17, 32'h0000_0021));
    b_cmd = cmd_pushes; b_rd = rd_strobes; b_done = done_cnt;
    issue_req(1'b0, 32'h0000_0020, 16'd3, acc);
    wait_done(b_done, 2000);
    repeat (20) tick_sample();
    check("t3_status", 72'(done_status), 72'd1);
    check("t3_card", 72'(done_card), 72'h900);
    check("t3_cmd_count", 72'(cmd_pushes - b_cmd), 72'd2);
    check("t3_rd_count", 72'(rd_strobes - b_rd), 72'd64);
    check("t3_blk1_undrained", 72'(rdq.size()), 72'd64);
    clear_env();

    // Timeout: result never offered.
    stall_rd = 1'b0;
    hold_results = 1'b1;
    res_script.push_back({4'h0, 32'h0000_0000});
    exp_cmd.push_back(mk_cmd(6'd17, 32'h0000_0005));
    b_cmd = cmd_pushes; b_res = res_pops; b_done = done_cnt;
    issue_req(1'b0, 32'h0000_0005, 16'd1, acc);
    wait_done(b_done, 400);
    check("t4_status", 72'(done_status), 72'd2);
    // WAIT_RES occupies the 100 cycles after the push cycle; DONE is the next one.
    check("t4_latency", 72'(done_cyc - last_cmd_cyc), 72'd101);
    check("t4_cmd_count", 72'(cmd_pushes - b_cmd), 72'd1);
    check("t4_no_pop", 72'(res_pops - b_res), 72'd0);
    hold_results = 1'b0;
    clear_env();

    // Zero-block request.
    b_cmd = cmd_pushes; b_data = data_pushes; b_done = done_cnt;
    issue_req(1'b1, 32'h0000_1234, 16'd0, acc);
    wait_done(b_done, 10);
    check("t5_latency", 72'(done_cyc), 72'(acc + 1));
    check("t5_status", 72'(done_status), 72'd0);
    check("t5_card", 72'(done_card), 72'd0);
    check("t5_cmd_count", 72'(cmd_pushes - b_cmd), 72'd0);
    check("t5_data_count", 72'(data_pushes - b_data), 72'd0);

    // Reset in the middle of a block drain, then a clean read.
    stall_rd = 1'b1;
    res_script.push_back({4'h0, 32'h0000_0077});
    exp_cmd.push_back(mk_cmd(6'd17, 32'h0000_0300));
    b_rd = rd_strobes; b_done = done_cnt;
    issue_req(1'b0, 32'h0000_0300, 16'd1, acc);
    n = 0;
    while (rd_strobes - b_rd < 10 && n < 500) begin
      tick_sample();
      n++;
    end
    if (rd_strobes - b_rd < 10) check("t6_drain_expired", 72'(rd_strobes - b_rd), 72'd10);
    tick_drive();
    sysRst = 1'b1;
    tick_drive();
    sysRst = 1'b0;
    tick_sample();
    check("t6_cmdWrEn", 72'(cmdFifoWrEn), 72'd0);
    check("t6_dataWrEn", 72'(cmdDataFifoWrEn), 72'd0);
    check("t6_resRdEn", 72'(resultFifoRdEn), 72'd0);
    check("t6_rdDataRdEn", 72'(resultDataFifoRdEn), 72'd0);
    check("t6_rdValid", 72'(rdValid), 72'd0);
    check("t6_done", 72'(doneStrobe), 72'd0);
    check("t6_reqReady", 72'(reqReady), 72'd1);
    repeat (5) tick_sample();
    check("t6_no_done", 72'(done_cnt), 72'(b_done));
    clear_env();

    res_script.push_back({4'h0, 32'h0000_0099});
    exp_cmd.push_back(mk_cmd(6'd17, 32'h0000_0400));
    b_rd = rd_strobes; b_done = done_cnt;
    issue_req(1'b0, 32'h0000_0400, 16'd1, acc);
    wait_done(b_done, 1000);
    check("t6b_status", 72'(done_status), 72'd0);
    check("t6b_card", 72'(done_card), 72'h99);
    check("t6b_rd_count", 72'(rd_strobes - b_rd), 72'd64);
    check("t6b_rd_left", 72'(exp_rd.size()), 72'd0);

    repeat (3) tick_sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
